// File: rtl/i2s_pkg.sv
// Shared constants for the I2S receive master: parameter defaults and FSM state codes.
package i2s_pkg;

    localparam int N_LINES_DEF    = 1;
    localparam int SAMPLE_W_DEF   = 24;
    localparam int SLOT_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int DIV_W_DEF      = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/i2s_rx_master_if.sv
// Pop-side bundle of the receive FIFO: head word, its channel and the valid/ready handshake.
interface i2s_rx_master_if
    import i2s_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W_DEF
);

    logic [DATA_W-1:0] rd_data;
    logic              rd_chan;
    logic              rd_valid;
    logic              rd_ready;

    modport master (output rd_data, output rd_chan, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_chan, input rd_valid, output rd_ready);

endinterface

// File: rtl/i2s_fifo.sv
// Synchronous FIFO of {data, channel} words with occupancy and a sticky overflow flag.
module i2s_fifo
    import i2s_pkg::*;
#(
    parameter  int DATA_W = SAMPLE_W_DEF,
    parameter  int DEPTH  = FIFO_DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wchan,
    input  logic              ovf_clr,
    i2s_rx_master_if.master   rd,
    output logic [LW-1:0]     level,
    output logic              overflow
);

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            valid_q, ovf_q, ovf_d;
    logic            full_s, pop_s, wr_s, drop_s;

    // A push while full still lands when the head is popped in the same cycle.
    always_comb begin
        full_s   = (cnt_q == LVL_FULL);
        pop_s    = valid_q && rd.rd_ready;
        wr_s     = push && (!full_s || pop_s);
        drop_s   = push && full_s && !pop_s;
        wr_ptr_d = wr_s  ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({wr_s, pop_s})
            2'b10:   cnt_d = cnt_q + LVL_ONE;
            2'b01:   cnt_d = cnt_q - LVL_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Storage, pointers and flags; storage is cleared so the head reads zero before the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_s) mem_q[wr_ptr_q] <= {wdata, wchan};
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= (cnt_d != '0);
            ovf_q    <= ovf_d;
        end
    end

    assign rd.rd_data  = mem_q[rd_ptr_q][DATA_W:1];
    assign rd.rd_chan  = mem_q[rd_ptr_q][0];
    assign rd.rd_valid = valid_q;
    assign level       = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: rtl/i2s_rx_master.sv
// I2S receive master: generates SCK/WS, deserialises N_LINES data lines and queues words in a FIFO.
module i2s_rx_master
    import i2s_pkg::*;
#(
    parameter int N_LINES    = N_LINES_DEF,
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int SLOT_W     = SLOT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DIV_W      = DIV_W_DEF
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic                             en,
    input  logic [DIV_W-1:0]                 clk_div,
    input  logic                             mono,
    input  logic [N_LINES-1:0]               sd_in,
    output logic                             i2s_clk,
    output logic                             ws,
    output logic [N_LINES*SAMPLE_W-1:0]      rd_data,
    output logic                             rd_chan,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             overflow,
    input  logic                             ovf_clr
);

    localparam int               DW       = N_LINES * SAMPLE_W;
    localparam int               BCW      = $clog2(SLOT_W);
    localparam logic [BCW-1:0]   BIT_LAST = BCW'(SLOT_W - 1);
    localparam logic [BCW-1:0]   BIT_CAP  = BCW'(SAMPLE_W);
    localparam logic [BCW-1:0]   BIT_ONE  = BCW'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [1:0]                       state_q, state_d;
    logic [DIV_W-1:0]                 div_q, div_d, div_cnt_q, div_cnt_d;
    logic                             sck_q, sck_d, ws_q, ws_d;
    logic [BCW-1:0]                   bit_cnt_q, bit_cnt_d;
    logic [N_LINES-1:0][SAMPLE_W-1:0] shift_q, shift_d;
    logic                             chan_q, chan_d, pend_q, pend_d;
    logic                             tick_s, rise_s, fall_s, push_s;

    // SCK/WS generation, bit capture and the IDLE/SYNC/RUN sequencing.
    always_comb begin
        tick_s    = (div_cnt_q == div_q);
        rise_s    = tick_s && !sck_q;
        fall_s    = tick_s && sck_q;
        state_d   = state_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        ws_d      = ws_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        chan_d    = chan_q;
        pend_d    = 1'b0;
        if (!en) begin
            state_d   = ST_IDLE;
            div_cnt_d = '0;
            sck_d     = 1'b0;
            ws_d      = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
            chan_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_SYNC;
                    div_d     = (clk_div == '0) ? DIV_ONE : clk_div;
                    div_cnt_d = '0;
                    sck_d     = 1'b0;
                    ws_d      = 1'b0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
                ST_SYNC, ST_RUN: begin
                    if (tick_s) begin
                        div_cnt_d = '0;
                        sck_d     = !sck_q;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_ONE;
                    end
                    // A left slot begins when WS falls; only then is word alignment known.
                    if (fall_s && (bit_cnt_q == BIT_LAST)) begin
                        bit_cnt_d = '0;
                        ws_d      = !ws_q;
                        if ((state_q == ST_SYNC) && ws_q) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = state_q;
                        end
                    end else if (fall_s) begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                    if (rise_s && (bit_cnt_q != '0) && (bit_cnt_q <= BIT_CAP)) begin
                        for (int k = 0; k < N_LINES; k++) begin
                            shift_d[k] = {shift_q[k][SAMPLE_W-2:0], sd_in[k]};
                        end
                        chan_d = ws_q;
                        pend_d = (bit_cnt_q == BIT_CAP) && (state_q == ST_RUN);
                    end else begin
                        shift_d = shift_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            div_q     <= DIV_ONE;
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            chan_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            chan_q    <= chan_d;
            pend_q    <= pend_d;
        end
    end

    assign push_s  = pend_q && !(mono && chan_q);
    assign i2s_clk = sck_q;
    assign ws      = ws_q;

    i2s_rx_master_if #(.DATA_W(DW)) rd_bus ();

    assign rd_bus.rd_ready = rd_ready;
    assign rd_data         = rd_bus.rd_data;
    assign rd_chan         = rd_bus.rd_chan;
    assign rd_valid        = rd_bus.rd_valid;

    i2s_fifo #(
        .DATA_W (DW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .push     (push_s),
        .wdata    (shift_q),
        .wchan    (chan_q),
        .ovf_clr  (ovf_clr),
        .rd       (rd_bus),
        .level    (level),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_i2s_rx_master.sv
// Directed bench for i2s_rx_master with a two-line I2S transmitter model driving sd_in.
module tb_i2s_rx_master;

    localparam int NL = 2;
    localparam int SW = 24;
    localparam int DW = NL * SW;
    localparam int LW = 4;

    logic          HCLK    = 1'b0;
    logic          HRESETn = 1'b0;
    logic          en      = 1'b0;
    logic          mono    = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [7:0]    clk_div = 8'd1;
    logic [NL-1:0] sd_in;
    logic          i2s_clk, ws, overflow;
    logic [LW-1:0] level;

    i2s_rx_master_if #(.DATA_W(DW)) rd_if ();

    logic [SW-1:0] lw [NL];
    logic [SW-1:0] rw [NL];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            tx_idx   = 0;
    logic          ws_last  = 1'b0;
    logic          sck_prev = 1'b0;
    int            p;

    always #5 HCLK = ~HCLK;

    i2s_rx_master #(
        .N_LINES(NL), .SAMPLE_W(SW), .SLOT_W(32), .FIFO_DEPTH(8), .DIV_W(8)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .en       (en),
        .clk_div  (clk_div),
        .mono     (mono),
        .sd_in    (sd_in),
        .i2s_clk  (i2s_clk),
        .ws       (ws),
        .rd_data  (rd_if.rd_data),
        .rd_chan  (rd_if.rd_chan),
        .rd_valid (rd_if.rd_valid),
        .rd_ready (rd_if.rd_ready),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    // Transmitter: MSB goes out on the SCK fall after the WS change, then one bit per fall.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            sd_in    = '0;
            tx_idx   = 0;
            ws_last  = 1'b0;
            sck_prev = 1'b0;
        end else begin
            if (sck_prev && !i2s_clk) begin
                if (ws !== ws_last) tx_idx = 0;
                else                tx_idx = tx_idx + 1;
                ws_last = ws;
                for (int k = 0; k < NL; k++) begin
                    if (tx_idx >= 1 && tx_idx <= SW) sd_in[k] = ws ? rw[k][SW-tx_idx] : lw[k][SW-tx_idx];
                    else                             sd_in[k] = 1'b0;
                end
            end
            sck_prev = i2s_clk;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic pop1();
        rd_if.rd_ready = 1'b1;
        @(negedge HCLK);
        rd_if.rd_ready = 1'b0;
    endtask

    task automatic wait_level(input string tag, input int target, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (int'(level) == target) begin ok = 1'b1; break; end
            @(negedge HCLK);
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic wait_ws(input string tag, input logic val, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge HCLK);
            if (ws === val) begin ok = 1'b1; break; end
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic wait_ovf(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge HCLK);
            if (overflow === 1'b1) begin ok = 1'b1; break; end
        end
        check("wait_overflow", ok, 1'b1);
    endtask

    task automatic wait_falls(input int n);
        int   seen = 0;
        logic prev = i2s_clk;
        for (int i = 0; i < 4000 && seen < n; i++) begin
            @(negedge HCLK);
            if (prev && !i2s_clk) seen++;
            prev = i2s_clk;
        end
        check("sck_falls_seen", seen, n);
    endtask

    task automatic measure_period(output int per);
        int   t0   = -1;
        logic prev = i2s_clk;
        per = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (!prev && i2s_clk) begin
                if (t0 < 0) t0 = i;
                else begin per = i - t0; break; end
            end
            prev = i2s_clk;
        end
    endtask

    initial begin
        rd_if.rd_ready = 1'b0;
        lw[0] = 24'hA5A5A5; rw[0] = 24'h123456;
        lw[1] = 24'h5A5A5A; rw[1] = 24'hEDCBA9;
        cycles(3);
        check("rst_i2s_clk",  i2s_clk, 1'b0);
        check("rst_ws",       ws, 1'b0);
        check("rst_rd_valid", rd_if.rd_valid, 1'b0);
        check("rst_level",    level, 4'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_rd_data",  rd_if.rd_data, 48'h0);
        check("rst_rd_chan",  rd_if.rd_chan, 1'b0);
        HRESETn = 1'b1;
        cycles(2);

        // Stereo capture, SCK from clk_div=1
        clk_div = 8'd1;
        en = 1'b1;
        measure_period(p);
        check("sck_period_div1", p, 4);
        wait_level("stereo_two_words", 2, 3000);
        en = 1'b0;
        cycles(2);
        check("stereo_left_data",  rd_if.rd_data, 48'h5A5A5A_A5A5A5);
        check("stereo_left_chan",  rd_if.rd_chan, 1'b0);
        pop1();
        check("stereo_right_data", rd_if.rd_data, 48'hEDCBA9_123456);
        check("stereo_right_chan", rd_if.rd_chan, 1'b1);
        pop1();
        check("stereo_drained_level", level, 4'd0);
        check("stereo_drained_valid", rd_if.rd_valid, 1'b0);

        // Mono with distinct line patterns
        lw[0] = 24'h000001; rw[0] = 24'h800000;
        lw[1] = 24'hFFFFFF; rw[1] = 24'h7FFFFF;
        mono = 1'b1;
        en   = 1'b1;
        wait_level("mono_three_words", 3, 4000);
        en   = 1'b0;
        mono = 1'b0;
        cycles(2);
        for (int i = 0; i < 3; i++) begin
            check("mono_data", rd_if.rd_data, 48'hFFFFFF_000001);
            check("mono_chan", rd_if.rd_chan, 1'b0);
            pop1();
        end
        check("mono_drained_level", level, 4'd0);

        // Overflow with no reader
        lw[0] = 24'h111111; rw[0] = 24'h222222;
        lw[1] = 24'h333333; rw[1] = 24'h444444;
        en = 1'b1;
        wait_ovf(5000);
        en = 1'b0;
        cycles(2);
        check("ovf_level_full", level, 4'd8);
        check("ovf_flag",       overflow, 1'b1);
        check("ovf_head_data",  rd_if.rd_data, 48'h333333_111111);
        check("ovf_head_chan",  rd_if.rd_chan, 1'b0);
        pop1();
        check("ovf_second_data", rd_if.rd_data, 48'h444444_222222);
        check("ovf_second_chan", rd_if.rd_chan, 1'b1);
        check("ovf_level_after_pop", level, 4'd7);
        ovf_clr = 1'b1;
        @(negedge HCLK);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        rd_if.rd_ready = 1'b1;
        cycles(10);
        rd_if.rd_ready = 1'b0;
        check("ovf_drained_level", level, 4'd0);

        // Enable dropped at bit 10 of a left slot
        lw[0] = 24'hABCDEF; rw[0] = 24'h654321;
        lw[1] = 24'h0F0F0F; rw[1] = 24'hF0F0F0;
        en = 1'b1;
        wait_level("drop_first_word", 1, 3000);
        pop1();
        wait_ws("drop_wait_right", 1'b1, 2000);
        wait_ws("drop_wait_left", 1'b0, 2000);
        pop1();
        wait_falls(10);
        en = 1'b0;
        lw[0] = 24'h13579B;
        lw[1] = 24'h2468AC;
        cycles(1);
        check("drop_idle_sck", i2s_clk, 1'b0);
        check("drop_idle_ws",  ws, 1'b0);
        cycles(100);
        check("drop_no_partial", level, 4'd0);
        en = 1'b1;
        wait_level("restart_word", 1, 3000);
        check("restart_data", rd_if.rd_data, 48'h2468AC_13579B);
        check("restart_chan", rd_if.rd_chan, 1'b0);
        en = 1'b0;
        pop1();
        cycles(2);

        // clk_div=0 behaves as 1; live clk_div changes ignored; async reset mid-frame
        clk_div = 8'd0;
        en = 1'b1;
        measure_period(p);
        check("sck_period_div0", p, 4);
        clk_div = 8'd5;
        measure_period(p);
        check("sck_period_div_change_ignored", p, 4);
        wait_level("reset_prefill", 1, 3000);
        wait_ws("reset_wait_right", 1'b1, 2000);
        cycles(3);
        HRESETn = 1'b0;
        #1;
        check("mid_rst_i2s_clk",  i2s_clk, 1'b0);
        check("mid_rst_ws",       ws, 1'b0);
        check("mid_rst_rd_valid", rd_if.rd_valid, 1'b0);
        check("mid_rst_level",    level, 4'd0);
        check("mid_rst_overflow", overflow, 1'b0);
        check("mid_rst_rd_data",  rd_if.rd_data, 48'h0);
        check("mid_rst_rd_chan",  rd_if.rd_chan, 1'b0);
        en = 1'b0;
        cycles(2);
        HRESETn = 1'b1;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
